// File: rtl/irq_ctrl.sv
// Platform interrupt controller: per-source gateways, priority/threshold arbiter, claim/complete port.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every src_i bit.
module irq_ctrl #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               irq_external_o
);

    localparam int ID_W = $clog2(NUM_SRC + 1);
    localparam logic [5:0] W_PENDING   = 6'd32;
    localparam logic [5:0] W_ENABLE    = 6'd33;
    localparam logic [5:0] W_THRESHOLD = 6'd34;
    localparam logic [5:0] W_CLAIM     = 6'd35;

    logic [NUM_SRC-1:0] src_s;
    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] in_service_r;
    logic [NUM_SRC-1:0] enable_r;
    logic [PRIO_W-1:0]  threshold_r;
    logic [PRIO_W-1:0]  prio_r [NUM_SRC];
    logic [ID_W-1:0]    best_id_q;
    logic               irq_r;
    logic [31:0]        data_r;

    logic [5:0]         word_s;
    logic               wr_s;
    logic               rd_s;
    logic               claim_s;
    logic               complete_s;
    logic [NUM_SRC-1:0] pending_nxt_s;
    logic [NUM_SRC-1:0] in_service_nxt_s;
    logic [ID_W-1:0]    best_id_nxt_s;
    logic [PRIO_W-1:0]  best_prio_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_a_r;
    logic [NUM_SRC-1:0] sync_b_r;

    // Two-stage synchronizer for asynchronous peripheral lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_r <= {NUM_SRC{1'b0}};
            sync_b_r <= {NUM_SRC{1'b0}};
        end else begin
            sync_a_r <= src_i;
            sync_b_r <= sync_a_r;
        end
    end
    assign src_s = sync_b_r;
`else
    assign src_s = src_i;
`endif

    // Word-aligned decode: the byte-offset bits and upper address bits are ignored
    assign word_s     = addr_i[7:2];
    assign wr_s       = req_i & we_i;
    assign rd_s       = req_i & ~we_i;
    assign claim_s    = rd_s && (word_s == W_CLAIM) && (best_id_q != {ID_W{1'b0}});
    assign complete_s = wr_s && (word_s == W_CLAIM);
    assign unused_s   = ^{addr_i[31:8], addr_i[1:0]};

    // Gateway next state: claim and complete take precedence over a new pend on the same source
    always_comb begin
        pending_nxt_s    = pending_r;
        in_service_nxt_s = in_service_r;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (claim_s && (best_id_q == ID_W'(k + 1))) begin
                pending_nxt_s[k]    = 1'b0;
                in_service_nxt_s[k] = 1'b1;
            end else if (complete_s && (data_i == 32'(k + 1)) && in_service_r[k]) begin
                in_service_nxt_s[k] = 1'b0;
            end else if (src_s[k] && !pending_r[k] && !in_service_r[k]) begin
                pending_nxt_s[k] = 1'b1;
            end else begin
                pending_nxt_s[k] = pending_r[k];
            end
        end
    end

    // Arbiter: strict '>' in ascending ID order keeps the lowest ID on a priority tie
    always_comb begin
        best_id_nxt_s = {ID_W{1'b0}};
        best_prio_s   = {PRIO_W{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (pending_r[k] && enable_r[k] && (prio_r[k] > threshold_r) && (prio_r[k] > best_prio_s)) begin
                best_prio_s   = prio_r[k];
                best_id_nxt_s = ID_W'(k + 1);
            end else begin
                best_prio_s = best_prio_s;
            end
        end
    end

    // Read data mux; unmapped words read as zero
    always_comb begin
        rdata_s = 32'd0;
        case (word_s)
            W_PENDING:   rdata_s = 32'(pending_r);
            W_ENABLE:    rdata_s = 32'(enable_r);
            W_THRESHOLD: rdata_s = 32'(threshold_r);
            W_CLAIM:     rdata_s = 32'(best_id_q);
            default: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    if (word_s == 6'(k)) begin
                        rdata_s = 32'(prio_r[k]);
                    end else begin
                        rdata_s = rdata_s;
                    end
                end
            end
        endcase
    end

    // Gateway state, arbitration result and interrupt output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= {NUM_SRC{1'b0}};
            in_service_r <= {NUM_SRC{1'b0}};
            best_id_q    <= {ID_W{1'b0}};
            irq_r        <= 1'b0;
        end else begin
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
            best_id_q    <= best_id_nxt_s;
            irq_r        <= (best_id_nxt_s != {ID_W{1'b0}});
        end
    end

    // Software-visible configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r    <= {NUM_SRC{1'b0}};
            threshold_r <= {PRIO_W{1'b0}};
            for (int k = 0; k < NUM_SRC; k++) begin
                prio_r[k] <= {PRIO_W{1'b0}};
            end
        end else begin
            if (wr_s && (word_s == W_ENABLE)) begin
                enable_r <= data_i[NUM_SRC-1:0];
            end
            if (wr_s && (word_s == W_THRESHOLD)) begin
                threshold_r <= data_i[PRIO_W-1:0];
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                if (wr_s && (word_s == 6'(k))) begin
                    prio_r[k] <= data_i[PRIO_W-1:0];
                end
            end
        end
    end

    // Read data register, held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= 32'd0;
        end else if (rd_s) begin
            data_r <= rdata_s;
        end
    end

    assign data_o         = data_r;
    assign irq_external_o = irq_r;

endmodule
